// File: rtl/bin2bcd_serial_pkg.sv
// Shared calculator package: BCD digit type, converter state encoding and default sizes.
// Imported by bin2bcd_serial and bcd_digit_adj.
package calc_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int DEF_WIDTH      = 14;
   localparam int DEF_DIGITS     = 4;
   localparam int DEF_SCR_DIGITS = DEF_DIGITS + 1;

endpackage

// File: rtl/bin2bcd_serial_digit_adj.sv
// Single BCD digit correction cell for shift-and-add-3: digits of 5 or more get +3
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  bcd_digit_t d_i,
   output bcd_digit_t d_o
);

   assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter, one input bit per clock, start/done handshake.
// Build option: define BIN2BCD_SATURATE_EN to clamp overflowing results to all nines.
module bin2bcd_serial
   import calc_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      bin_in,
   input  logic                  start,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int SCR_DIGITS = DIGITS + (DEF_SCR_DIGITS - DEF_DIGITS);
   localparam int SCR_W      = 4 * SCR_DIGITS;
   localparam int CNT_W      = $clog2(WIDTH + 1);

   localparam logic [0:0] S_IDLE  = ST_IDLE;
   localparam logic [0:0] S_SHIFT = ST_SHIFT;

   logic [0:0]          state_q, state_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [SCR_W-1:0]    scratch_q, scratch_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;

   logic [SCR_W-1:0]    scratch_adj;
   logic [SCR_W-1:0]    scratch_sh;
   logic                ovf_now;
   logic [4*DIGITS-1:0] result_now;

   for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_i (scratch_q[4*g +: 4]),
         .d_o (scratch_adj[4*g +: 4])
      );
   end

   // Add-3 happens before the shift within the same iteration.
   assign scratch_sh = {scratch_adj[SCR_W-2:0], shift_q[WIDTH-1]};
   assign ovf_now    = (scratch_sh[SCR_W-1 -: 4] != 4'd0);

`ifdef BIN2BCD_SATURATE_EN
   assign result_now = ovf_now ? {DIGITS{4'h9}} : scratch_sh[4*DIGITS-1:0];
`else
   assign result_now = scratch_sh[4*DIGITS-1:0];
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d   = bin_in;
               scratch_d = '0;
               cnt_d     = CNT_W'(WIDTH);
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            scratch_d = scratch_sh;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = result_now;
               ovf_d   = ovf_now;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   // The operand shift register needs no reset: it is always loaded on start.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign ready    = (state_q == S_IDLE);
   assign busy     = (state_q == S_SHIFT);
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_q;

endmodule
